// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stall/flush controller.
//   REG_IDX_W     : width of a register-file index
//   stage_en_t    : per-stage register load enables
//   stage_flush_t : per-stage register flush (load NOP) strobes
//   adv_mode_t    : what the pipeline does in the current cycle
package pipe_pkg;

  localparam int unsigned REG_IDX_W = 5;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } stage_en_t;

  typedef struct packed {
    logic if_id;
    logic id_ex;
  } stage_flush_t;

  typedef enum logic [1:0] {
    MODE_STALL  = 2'd0,  // a memory port is still waiting: freeze everything
    MODE_FLUSH  = 2'd1,  // taken redirect: squash the two younger instructions
    MODE_BUBBLE = 2'd2,  // load-use: hold PC/IF_ID, inject NOP into ID_EX
    MODE_RUN    = 2'd3   // normal advance
  } adv_mode_t;

  localparam stage_en_t    EN_NONE = '0;
  localparam stage_en_t    EN_ALL  = '1;
  localparam stage_flush_t FL_NONE = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
//   clk   : clock
//   reset : synchronous, active-high clear
//   inc   : count one event this cycle
//   count : current value; sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the 5-stage RV32I pipeline.
// Drives the load/flush strobes of every pipeline register, arbitrates the
// instruction/data memory handshakes, detects load-use hazards and taken
// branches, and keeps saturating stall/bubble/flush counters.
//   clk, reset                  : clock, synchronous active-high reset
//   imem_read / imem_resp       : fetch request / one-cycle data-valid pulse
//   mem_op, dmem_req, dmem_resp : EX_MEM data access, request gate, done pulse
//   id_rs1/2, id_use_rs1/2      : IF_ID source registers and their use flags
//   ex_is_load, ex_rd           : ID_EX load flag and destination register
//   br_taken                    : ID_EX instruction redirects the PC
//   load_*                      : PC and stage register enables
//   flush_if_id, flush_id_ex    : load NOP instead of upstream data
//   stall_cnt/bubble_cnt/flush_cnt : saturating performance counters
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_read,
  input  logic                 imem_resp,
  input  logic                 mem_op,
  output logic                 dmem_req,
  input  logic                 dmem_resp,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic                 ex_is_load,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 br_taken,
  output logic                 load_pc,
  output logic                 load_if_id,
  output logic                 load_id_ex,
  output logic                 load_ex_mem,
  output logic                 load_mem_wb,
  output logic                 flush_if_id,
  output logic                 flush_id_ex,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  // Response already seen on a port while the other port was still waiting.
  logic r_i_done;
  logic r_d_done;

  logic         w_i_ok;
  logic         w_d_ok;
  logic         w_adv;
  logic         w_hazard;
  adv_mode_t    w_mode;
  stage_en_t    w_en;
  stage_flush_t w_fl;

  // Responses during reset are ignored, so the ok terms are gated by reset;
  // this also keeps every load/flush strobe low while reset is held.
  assign w_i_ok = !reset & (r_i_done | imem_resp);
  assign w_d_ok = !reset & (!mem_op | r_d_done | dmem_resp);
  assign w_adv  = w_i_ok & w_d_ok;

  assign imem_read = !reset & !r_i_done;
  assign dmem_req  = !reset & mem_op & !r_d_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
    end else if (w_adv) begin
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
    end else begin
      if (imem_resp) begin
        r_i_done <= 1'b1;
      end
      if (mem_op && dmem_resp) begin
        r_d_done <= 1'b1;
      end
    end
  end

  // x0 is never a real producer, so a load to x0 cannot create a hazard.
  assign w_hazard = ex_is_load & (ex_rd != '0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) |
                     (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    w_mode = MODE_STALL;
    if (w_adv) begin
      if (br_taken) begin
        w_mode = MODE_FLUSH;
      end else if (w_hazard) begin
        w_mode = MODE_BUBBLE;
      end else begin
        w_mode = MODE_RUN;
      end
    end
  end

  always_comb begin
    w_en = EN_NONE;
    w_fl = FL_NONE;
    unique case (w_mode)
      MODE_STALL: begin
        w_en = EN_NONE;
        w_fl = FL_NONE;
      end
      MODE_FLUSH: begin
        w_en       = EN_ALL;
        w_fl.if_id = 1'b1;
        w_fl.id_ex = 1'b1;
      end
      MODE_BUBBLE: begin
        // Older stages drain while PC and IF_ID hold the dependent instruction.
        w_en.pc     = 1'b0;
        w_en.if_id  = 1'b0;
        w_en.id_ex  = 1'b1;
        w_en.ex_mem = 1'b1;
        w_en.mem_wb = 1'b1;
        w_fl.id_ex  = 1'b1;
      end
      MODE_RUN: begin
        w_en = EN_ALL;
        w_fl = FL_NONE;
      end
      default: begin
        w_en = EN_NONE;
        w_fl = FL_NONE;
      end
    endcase
  end

  assign load_pc     = w_en.pc;
  assign load_if_id  = w_en.if_id;
  assign load_id_ex  = w_en.id_ex;
  assign load_ex_mem = w_en.ex_mem;
  assign load_mem_wb = w_en.mem_wb;
  assign flush_if_id = w_fl.if_id;
  assign flush_id_ex = w_fl.id_ex;

  logic w_inc_stall;
  logic w_inc_bubble;
  logic w_inc_flush;

  assign w_inc_stall  = (w_mode == MODE_STALL);
  assign w_inc_bubble = (w_mode == MODE_BUBBLE);
  assign w_inc_flush  = (w_mode == MODE_FLUSH);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_inc_stall),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_inc_bubble),
    .count (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_inc_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (CNT_W = 4 so saturation is
// reachable quickly). Inputs change 1 ns after the rising edge; combinational
// outputs are checked 2 ns later, counters after the following edge.
module tb_pipe_ctrl;

  localparam int unsigned CW = 4;

  logic          clk;
  logic          reset;
  logic          imem_read;
  logic          imem_resp;
  logic          mem_op;
  logic          dmem_req;
  logic          dmem_resp;
  logic [4:0]    id_rs1;
  logic [4:0]    id_rs2;
  logic          id_use_rs1;
  logic          id_use_rs2;
  logic          ex_is_load;
  logic [4:0]    ex_rd;
  logic          br_taken;
  logic          load_pc;
  logic          load_if_id;
  logic          load_id_ex;
  logic          load_ex_mem;
  logic          load_mem_wb;
  logic          flush_if_id;
  logic          flush_id_ex;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;
  logic [CW-1:0] flush_cnt;

  int unsigned n_tot;
  int unsigned n_bad;

  pipe_ctrl #(.CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_read   (imem_read),
    .imem_resp   (imem_resp),
    .mem_op      (mem_op),
    .dmem_req    (dmem_req),
    .dmem_resp   (dmem_resp),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_is_load  (ex_is_load),
    .ex_rd       (ex_rd),
    .br_taken    (br_taken),
    .load_pc     (load_pc),
    .load_if_id  (load_if_id),
    .load_id_ex  (load_id_ex),
    .load_ex_mem (load_ex_mem),
    .load_mem_wb (load_mem_wb),
    .flush_if_id (flush_if_id),
    .flush_id_ex (flush_id_ex),
    .stall_cnt   (stall_cnt),
    .bubble_cnt  (bubble_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc, if_id, id_ex, ex_mem, mem_wb} and {if_id, id_ex}
  logic [4:0] ld;
  logic [1:0] fl;
  logic [1:0] rq;
  assign ld = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb};
  assign fl = {flush_if_id, flush_id_ex};
  assign rq = {imem_read, dmem_req};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    imem_resp  = 1'b0;
    mem_op     = 1'b0;
    dmem_resp  = 1'b0;
    id_rs1     = 5'd0;
    id_rs2     = 5'd0;
    id_use_rs1 = 1'b0;
    id_use_rs2 = 1'b0;
    ex_is_load = 1'b0;
    ex_rd      = 5'd0;
    br_taken   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_tot = 0;
    n_bad = 0;
    reset = 1'b1;
    idle_inputs();

    // Reset held 3 cycles with both responses pulsing: everything stays 0.
    imem_resp = 1'b1;
    mem_op    = 1'b1;
    dmem_resp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("rst_req", 32'(rq), 32'h0);
      chk("rst_ld", 32'(ld), 32'h0);
      chk("rst_fl", 32'(fl), 32'h0);
      tick();
    end
    chk("rst_cnt", 32'({stall_cnt, bubble_cnt, flush_cnt}), 32'h0);

    // First cycle after reset: fetch requested, zero-wait responses advance.
    reset = 1'b0;
    settle();
    chk("c1_imem_read", 32'(imem_read), 32'h1);
    chk("c1_dmem_req", 32'(dmem_req), 32'h1);
    chk("c1_ld", 32'(ld), 32'h1f);
    chk("c1_fl", 32'(fl), 32'h0);
    tick();
    chk("c1_cnt", 32'({stall_cnt, bubble_cnt, flush_cnt}), 32'h0);

    // Zero-wait memories: advance every cycle, no stalls accumulate.
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("zw_ld", 32'(ld), 32'h1f);
      tick();
    end
    chk("zw_stall", 32'(stall_cnt), 32'h0);

    // imem_resp delayed 3 cycles, mem_op=0.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("iw_read", 32'(imem_read), 32'h1);
      chk("iw_ld", 32'(ld), 32'h0);
      tick();
    end
    imem_resp = 1'b1;
    settle();
    chk("iw_read_resp", 32'(imem_read), 32'h1);
    chk("iw_ld_resp", 32'(ld), 32'h1f);
    tick();
    chk("iw_stall", 32'(stall_cnt), 32'h3);

    // mem_op=1, imem_resp at cycle 1, dmem_resp at cycle 4.
    do_reset();
    mem_op = 1'b1;
    settle();
    chk("dw0_req", 32'(rq), 32'h3);
    chk("dw0_ld", 32'(ld), 32'h0);
    tick();
    imem_resp = 1'b1;
    settle();
    chk("dw1_req", 32'(rq), 32'h3);
    chk("dw1_ld", 32'(ld), 32'h0);
    tick();
    imem_resp = 1'b0;
    for (int i = 2; i < 4; i++) begin
      settle();
      chk("dw23_req", 32'(rq), 32'h1);
      chk("dw23_ld", 32'(ld), 32'h0);
      tick();
    end
    dmem_resp = 1'b1;
    settle();
    chk("dw4_req", 32'(rq), 32'h1);
    chk("dw4_ld", 32'(ld), 32'h1f);
    tick();
    chk("dw_stall", 32'(stall_cnt), 32'h4);
    dmem_resp = 1'b0;
    mem_op    = 1'b0;
    settle();
    chk("dw5_req", 32'(rq), 32'h2);

    // Load-use hazard via rs2.
    do_reset();
    imem_resp  = 1'b1;
    ex_is_load = 1'b1;
    ex_rd      = 5'd5;
    id_rs2     = 5'd5;
    id_use_rs2 = 1'b1;
    id_rs1     = 5'd3;
    id_use_rs1 = 1'b1;
    settle();
    chk("hz_ld", 32'(ld), 32'h07);
    chk("hz_fl", 32'(fl), 32'h1);
    tick();
    chk("hz_bubble", 32'(bubble_cnt), 32'h1);
    // Load to x0 is never a hazard.
    ex_rd  = 5'd0;
    id_rs2 = 5'd0;
    settle();
    chk("hz_x0_ld", 32'(ld), 32'h1f);
    chk("hz_x0_fl", 32'(fl), 32'h0);
    tick();
    chk("hz_x0_bubble", 32'(bubble_cnt), 32'h1);
    // Match on rs1, but only when rs1 is actually used.
    ex_rd = 5'd3;
    settle();
    chk("hz_rs1_ld", 32'(ld), 32'h07);
    id_use_rs1 = 1'b0;
    settle();
    chk("hz_rs1_unused_ld", 32'(ld), 32'h1f);
    // Hazard with memory stalled: nothing moves, no bubble counted.
    id_use_rs1 = 1'b1;
    imem_resp  = 1'b0;
    settle();
    chk("hz_stall_ld", 32'(ld), 32'h0);
    chk("hz_stall_fl", 32'(fl), 32'h0);
    tick();
    chk("hz_stall_bubble", 32'(bubble_cnt), 32'h1);

    // Branch taken with a simultaneous hazard: branch wins.
    do_reset();
    imem_resp  = 1'b1;
    ex_is_load = 1'b1;
    ex_rd      = 5'd7;
    id_rs1     = 5'd7;
    id_use_rs1 = 1'b1;
    br_taken   = 1'b1;
    settle();
    chk("br_ld", 32'(ld), 32'h1f);
    chk("br_fl", 32'(fl), 32'h3);
    tick();
    chk("br_flush_cnt", 32'(flush_cnt), 32'h1);
    chk("br_bubble_cnt", 32'(bubble_cnt), 32'h0);
    // Branch while stalled: no strobes, no flush counted.
    imem_resp = 1'b0;
    settle();
    chk("br_stall_fl", 32'(fl), 32'h0);
    tick();
    chk("br_stall_flush_cnt", 32'(flush_cnt), 32'h1);

    // Saturation: imem stalled 20 cycles; d_done captured along the way.
    do_reset();
    mem_op = 1'b1;
    for (int i = 0; i < 20; i++) begin
      dmem_resp = (i == 2) ? 1'b1 : 1'b0;
      tick();
    end
    settle();
    chk("sat_dmem_req", 32'(dmem_req), 32'h0);
    chk("sat_stall", 32'(stall_cnt), 32'hf);
    // Reset mid-stall with a coincident dmem_resp.
    reset     = 1'b1;
    dmem_resp = 1'b1;
    settle();
    chk("midrst_req", 32'(rq), 32'h0);
    chk("midrst_ld", 32'(ld), 32'h0);
    tick();
    reset     = 1'b0;
    dmem_resp = 1'b0;
    settle();
    chk("post_rst_req", 32'(rq), 32'h3);
    chk("post_rst_stall", 32'(stall_cnt), 32'h0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
